// File: rtl/vga_ctrl.sv
// ---------------------------------------------------------------------------
// vga_ctrl -- 640x480@60 Hz VGA timing generator and pixel sink.
//
// Two free-running counters walk the 800x525 raster. Each clock, the
// counter position is turned into a pixel request (pos_x/pos_y/pos_valid)
// for the picture generator, which answers on pos_data DATA_LAT clocks
// later. The sync signals and the request-valid flag travel through a
// DATA_LAT-deep alignment pipe so that they arrive together with their
// pixel. Then the sync signals and the (blanked) colour are registered once
// more onto the pins. Everything on the connector therefore lags the
// counters by L = DATA_LAT+1 clocks. The sync-to-pixel spacing is the same
// as in the VESA raster.
//
// Ports:
//   vga_clk      in   1   pixel clock (25 MHz)
//   rst          in   1   asynchronous reset, active-high
//   pos_x        out  10  requested column 0..H_ACTIVE-1, 0 when blanked
//   pos_y        out  10  requested row 0..V_ACTIVE-1, 0 when blanked
//   pos_valid    out  1   request addresses a visible pixel
//   pos_data     in   24  RGB888 answer, valid DATA_LAT clocks after request
//   frame_start  out  1   one-clock pulse after the counters sit at (0,0)
//   hsync        out  1   horizontal sync, active-low, latency L
//   vsync        out  1   vertical sync, active-low, latency L
//   vga_rgb      out  12  {R[7:4],G[7:4],B[7:4]}, zero while blanked
// ---------------------------------------------------------------------------
module vga_ctrl #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int DATA_LAT = 1
) (
    input  logic        vga_clk,
    input  logic        rst,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        pos_valid,
    input  logic [23:0] pos_data,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] vga_rgb
);

    // ------------------------------------------------------------------
    // Raster geometry
    // ------------------------------------------------------------------
    localparam int H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_ACT_START = H_SYNC + H_BACK;
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int V_ACT_START = V_SYNC + V_BACK;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;
    localparam int HW          = $clog2(H_TOTAL);
    localparam int VW          = $clog2(V_TOTAL);

    // Sync/valid bundle carried through the alignment pipe. Syncs are kept
    // in pin polarity (low = sync) so the idle value is simply "all high,
    // not valid".
    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic valid;
    } align_t;

    localparam align_t ALIGN_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, valid: 1'b0};

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [HW-1:0] h_cnt_reg, h_cnt_next;
    logic [VW-1:0] v_cnt_reg, v_cnt_next;
    logic          h_last;
    logic          v_last;

    assign h_last = (h_cnt_reg == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt_reg == VW'(V_TOTAL - 1));

    always_comb begin
        h_cnt_next = h_cnt_reg + HW'(1);
        v_cnt_next = v_cnt_reg;
        if (h_last) begin
            h_cnt_next = '0;
            v_cnt_next = v_last ? '0 : v_cnt_reg + VW'(1);
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Region decode. The counters are widened by one bit so that an end
    // boundary equal to the total count still fits in the comparison.
    // ------------------------------------------------------------------
    logic [HW:0] h_ext;
    logic [VW:0] v_ext;
    logic        h_active;
    logic        v_active;
    logic        h_sync_on;
    logic        v_sync_on;

    assign h_ext     = {1'b0, h_cnt_reg};
    assign v_ext     = {1'b0, v_cnt_reg};
    assign h_active  = (h_ext >= (HW+1)'(H_ACT_START)) && (h_ext < (HW+1)'(H_ACT_END));
    assign v_active  = (v_ext >= (VW+1)'(V_ACT_START)) && (v_ext < (VW+1)'(V_ACT_END));
    assign h_sync_on = (h_ext < (HW+1)'(H_SYNC));
    assign v_sync_on = (v_ext < (VW+1)'(V_SYNC));

    // ------------------------------------------------------------------
    // Request stage (combinational from the counters)
    // ------------------------------------------------------------------
    assign pos_valid = h_active && v_active;
    assign pos_x     = pos_valid ? 10'(h_cnt_reg - HW'(H_ACT_START)) : 10'd0;
    assign pos_y     = pos_valid ? 10'(v_cnt_reg - VW'(V_ACT_START)) : 10'd0;

    // ------------------------------------------------------------------
    // Alignment pipe: delays syncs and valid by exactly the picture
    // generator latency, so that "aligned" describes the pixel that
    // pos_data is carrying right now.
    // ------------------------------------------------------------------
    align_t align_in;
    align_t aligned;

    assign align_in = '{hsync_n: ~h_sync_on, vsync_n: ~v_sync_on, valid: pos_valid};

    generate
        if (DATA_LAT == 0) begin : g_no_delay
            assign aligned = align_in;
        end else begin : g_delay
            align_t stage_reg [DATA_LAT];

            always_ff @(posedge vga_clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DATA_LAT; i++) begin
                        stage_reg[i] <= ALIGN_IDLE;
                    end
                end else begin
                    stage_reg[0] <= align_in;
                    for (int i = 1; i < DATA_LAT; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign aligned = stage_reg[DATA_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Colour reduction: keep the top nibble of each 8-bit channel.
    // Channel gi of the output sits at nibble gi; B is gi=0, R is gi=2.
    // ------------------------------------------------------------------
    logic [11:0] rgb_pix;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign rgb_pix[gi*4 +: 4] = pos_data[gi*8+4 +: 4];
        end
    endgenerate

    // The low nibbles are dropped by the 12-bit DAC on purpose.
    logic unused_pix_lsbs;
    assign unused_pix_lsbs = ^{pos_data[19:16], pos_data[11:8], pos_data[3:0]};

    // ------------------------------------------------------------------
    // Pin registers. frame_start is taken straight from the counters and
    // is deliberately not pipeline-aligned.
    // ------------------------------------------------------------------
    logic        hsync_reg;
    logic        vsync_reg;
    logic [11:0] rgb_reg;
    logic        frame_start_reg;
    logic        at_origin;

    assign at_origin = (h_cnt_reg == '0) && (v_cnt_reg == '0);

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            rgb_reg         <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            hsync_reg       <= aligned.hsync_n;
            vsync_reg       <= aligned.vsync_n;
            // Blank outside the visible window whatever pos_data holds.
            rgb_reg         <= aligned.valid ? rgb_pix : 12'd0;
            frame_start_reg <= at_origin;
        end
    end

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign vga_rgb     = rgb_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_ctrl -- self-checking bench for vga_ctrl.
//
// Four instances run side by side on one clock. Three use the full 640x480
// raster with DATA_LAT = 0, 1 and 3. The fourth uses a tiny raster with
// DATA_LAT = 2, so that many whole frames fit in the run.
//
// The reference model works from the number of clock edges k since reset
// release. The counter position is k mod frame, and the pins show position
// k-L. Expected outputs follow from plain arithmetic on that position.
//
// Each picture generator answers a request with a seeded pattern, or with
// random junk while blanked, delayed by that instance's DATA_LAT.
// ---------------------------------------------------------------------------
module tb_vga_ctrl;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst;
    logic [9:0]  pos_x_w       [4];
    logic [9:0]  pos_y_w       [4];
    logic        pos_valid_w   [4];
    logic [23:0] pos_data_r    [4];
    logic        frame_start_w [4];
    logic        hsync_w       [4];
    logic        vsync_w       [4];
    logic [11:0] vga_rgb_w     [4];

    // Per-instance geometry, mirrored by the parameter overrides below.
    int g_hs  [4] = '{96, 96, 96, 4};
    int g_hb  [4] = '{48, 48, 48, 3};
    int g_ha  [4] = '{640, 640, 640, 10};
    int g_hf  [4] = '{16, 16, 16, 2};
    int g_vs  [4] = '{2, 2, 2, 2};
    int g_vb  [4] = '{33, 33, 33, 3};
    int g_va  [4] = '{480, 480, 480, 6};
    int g_vf  [4] = '{10, 10, 10, 2};
    int g_lat [4] = '{0, 1, 3, 2};
    string tags [4] = '{"lat0_outs", "lat1_outs", "lat3_outs", "small_outs"};

    logic [23:0] seed [4];
    logic [23:0] hist [4][4];

    int checks   = 0;
    int failures = 0;

    // Aggregate counters (first run only).
    int fs_cnt   [4];
    int vis_cnt;
    int hs_lo_cnt;
    int vs_lo_cnt [4];
    int hs_fall_k [4];
    bit first_pix_seen [4];
    bit prev_hs [4];
    bit pix53_seen;

    vga_ctrl #(.DATA_LAT(0)) u_lat0 (
        .vga_clk(clk), .rst(rst), .pos_x(pos_x_w[0]), .pos_y(pos_y_w[0]),
        .pos_valid(pos_valid_w[0]), .pos_data(pos_data_r[0]),
        .frame_start(frame_start_w[0]), .hsync(hsync_w[0]), .vsync(vsync_w[0]),
        .vga_rgb(vga_rgb_w[0]));

    vga_ctrl #(.DATA_LAT(1)) u_lat1 (
        .vga_clk(clk), .rst(rst), .pos_x(pos_x_w[1]), .pos_y(pos_y_w[1]),
        .pos_valid(pos_valid_w[1]), .pos_data(pos_data_r[1]),
        .frame_start(frame_start_w[1]), .hsync(hsync_w[1]), .vsync(vsync_w[1]),
        .vga_rgb(vga_rgb_w[1]));

    vga_ctrl #(.DATA_LAT(3)) u_lat3 (
        .vga_clk(clk), .rst(rst), .pos_x(pos_x_w[2]), .pos_y(pos_y_w[2]),
        .pos_valid(pos_valid_w[2]), .pos_data(pos_data_r[2]),
        .frame_start(frame_start_w[2]), .hsync(hsync_w[2]), .vsync(vsync_w[2]),
        .vga_rgb(vga_rgb_w[2]));

    vga_ctrl #(
        .H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(3), .V_ACTIVE(6),  .V_FRONT(2),
        .DATA_LAT(2)
    ) u_small (
        .vga_clk(clk), .rst(rst), .pos_x(pos_x_w[3]), .pos_y(pos_y_w[3]),
        .pos_valid(pos_valid_w[3]), .pos_data(pos_data_r[3]),
        .frame_start(frame_start_w[3]), .hsync(hsync_w[3]), .vsync(vsync_w[3]),
        .vga_rgb(vga_rgb_w[3]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Picture pattern: column, row and a constant byte, each XORed with a seed.
    function automatic logic [23:0] pix(input int x, input int y, input logic [23:0] s);
        logic [7:0] xb;
        logic [7:0] yb;
        xb = 8'(x);
        yb = 8'(y);
        return {xb ^ s[23:16], yb ^ s[15:8], 8'hF0 ^ s[7:0]};
    endfunction

    // Expected {frame_start, hsync, vsync, pos_valid, pos_x, pos_y, vga_rgb}
    // after edge k since release (k = 0: in reset).
    function automatic logic [35:0] model(input int i, input int k);
        int ht, vt, ft, hs0, vs0, p, h, v, q, lat;
        logic vis, visq, fs, hsn, vsn;
        logic [9:0] px, py;
        logic [11:0] rgb;
        logic [23:0] d;
        ht  = g_hs[i] + g_hb[i] + g_ha[i] + g_hf[i];
        vt  = g_vs[i] + g_vb[i] + g_va[i] + g_vf[i];
        ft  = ht * vt;
        hs0 = g_hs[i] + g_hb[i];
        vs0 = g_vs[i] + g_vb[i];
        lat = g_lat[i] + 1;
        p   = k % ft;
        h   = p % ht;
        v   = p / ht;
        vis = (h >= hs0) && (h < hs0 + g_ha[i]) && (v >= vs0) && (v < vs0 + g_va[i]);
        px  = vis ? 10'(h - hs0) : 10'd0;
        py  = vis ? 10'(v - vs0) : 10'd0;
        fs  = (k >= 1) && (((k - 1) % ft) == 0);
        hsn = 1'b1;
        vsn = 1'b1;
        rgb = 12'd0;
        if (k >= lat) begin
            q    = (k - lat) % ft;
            h    = q % ht;
            v    = q / ht;
            hsn  = !(h < g_hs[i]);
            vsn  = !(v < g_vs[i]);
            visq = (h >= hs0) && (h < hs0 + g_ha[i]) && (v >= vs0) && (v < vs0 + g_va[i]);
            if (visq) begin
                d   = pix(h - hs0, v - vs0, seed[i]);
                rgb = {d[23:20], d[15:12], d[7:4]};
            end
        end
        return {fs, hsn, vsn, vis, px, py, rgb};
    endfunction

    // Check every instance at this negedge, then feed its picture generator.
    task automatic tick(input int k, input bit agg);
        logic [23:0] val;
        logic [35:0] obs;
        for (int i = 0; i < 4; i++) begin
            obs = {frame_start_w[i], hsync_w[i], vsync_w[i], pos_valid_w[i],
                   pos_x_w[i], pos_y_w[i], vga_rgb_w[i]};
            check(tags[i], 64'(obs), 64'(model(i, k)));

            if (agg) begin
                if (frame_start_w[i]) fs_cnt[i]++;
                if (!vsync_w[i]) vs_lo_cnt[i]++;
                if (i < 3) begin
                    if (prev_hs[i] && !hsync_w[i]) hs_fall_k[i] = k;
                    prev_hs[i] = hsync_w[i];
                    // Blue nibble is always F on these instances, so the
                    // first non-zero colour marks the first visible pixel.
                    if (!first_pix_seen[i] && vga_rgb_w[i] != 12'd0) begin
                        first_pix_seen[i] = 1'b1;
                        check("sync_to_pix", 64'(k - hs_fall_k[i]), 64'd144);
                        check("first_pix_k", 64'(k), 64'(35 * 800 + 144 + g_lat[i] + 1));
                    end
                end else begin
                    // Small raster: 125 whole frames (247 clocks each).
                    if (k < 125 * 247 && pos_valid_w[i]) vis_cnt++;
                    if (k >= 3 && k < 3 + 125 * 247 && !hsync_w[i]) hs_lo_cnt++;
                end
                if (i == 1 && k == 35 * 800 + 143)
                    check("pre_first_req", 64'(pos_valid_w[1]), 64'd0);
                if (i == 1 && k == 35 * 800 + 144)
                    check("first_req", 64'({pos_valid_w[1], pos_x_w[1], pos_y_w[1]}), 64'({1'b1, 20'd0}));
                if (i == 1 && k == 38 * 800 + 149 + 2) begin
                    pix53_seen = 1'b1;
                    check("pix_5_3", 64'(vga_rgb_w[1]), 64'h00F);
                end
            end

            val = pos_valid_w[i] ? pix(int'(pos_x_w[i]), int'(pos_y_w[i]), seed[i])
                                 : 24'($urandom);
            for (int j = 3; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = val;
            pos_data_r[i] = hist[i][g_lat[i]];
        end
    endtask

    task automatic run(input int n, input bit agg);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            tick(k, agg);
        end
    endtask

    localparam int RUN1 = 31000;

    initial begin
        seed[0] = {8'($urandom), 8'($urandom), 4'h0, 4'($urandom)};
        seed[1] = 24'h0;
        seed[2] = {8'($urandom), 8'($urandom), 4'h0, 4'($urandom)};
        seed[3] = 24'($urandom);
        for (int i = 0; i < 4; i++) begin
            pos_data_r[i]     = 24'd0;
            fs_cnt[i]         = 0;
            vs_lo_cnt[i]      = 0;
            hs_fall_k[i]      = 0;
            first_pix_seen[i] = 1'b0;
            prev_hs[i]        = 1'b1;
            for (int j = 0; j < 4; j++) hist[i][j] = 24'd0;
        end
        vis_cnt    = 0;
        hs_lo_cnt  = 0;
        pix53_seen = 1'b0;

        // Power-on reset.
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            tick(0, 1'b0);
        end
        rst = 1'b0;
        run(RUN1, 1'b1);

        // Frame-level aggregates.
        for (int i = 0; i < 3; i++) begin
            check("fs_count", 64'(fs_cnt[i]), 64'd1);
            check("vsync_low_clks", 64'(vs_lo_cnt[i]), 64'd1600);
            check("first_pix_seen", 64'(first_pix_seen[i]), 64'd1);
        end
        check("small_fs_count", 64'(fs_cnt[3]), 64'((RUN1 - 1) / 247 + 1));
        check("small_valid_clks", 64'(vis_cnt), 64'(125 * 10 * 6));
        check("small_hsync_low", 64'(hs_lo_cnt), 64'(125 * 13 * 4));
        check("pix_5_3_reached", 64'(pix53_seen), 64'd1);

        // Mid-line reset, asserted away from any clock edge.
        @(negedge clk);
        #5 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("async_rst",
                  64'({frame_start_w[i], hsync_w[i], vsync_w[i], pos_valid_w[i],
                       pos_x_w[i], pos_y_w[i], vga_rgb_w[i]}),
                  64'(model(i, 0)));
        end
        repeat (5) begin
            @(negedge clk);
            tick(0, 1'b0);
        end
        rst = 1'b0;
        run(1000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
